inst_fetch_unit: RTL and testbench

//  Read-side initiator for the synchronous instruction ROM. Drives the ROM address

---
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: sequential ROM addressing, one-cycle read-latency
// absorption, a prefetch FIFO toward decode and redirect with flush.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_50,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_s2_q, pc_s2_d;
  logic          v_s2_q, v_s2_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic          fifo_fault_q[DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  // The in-flight ROM read counts as occupied so a full FIFO can never be overrun.
  always_comb begin
    occupancy  = {1'b0, count_q} + (CW + 1)'(v_s2_q);
    issue      = !redirect && (occupancy < (CW + 1)'(DEPTH));
    push       = v_s2_q && !redirect;
    pop        = (count_q != '0) && out_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    pc_s2_d    = pc_s2_q;
    v_s2_d     = issue;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        pc_s2_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      pc_s2_q    <= '0;
      v_s2_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_s2_q    <= pc_s2_d;
      v_s2_q     <= v_s2_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entries are cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_inst_q[i]  <= '0;
        fifo_fault_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_s2_q;
      fifo_inst_q[wr_ptr_q]  <= imem_inst;
      fifo_fault_q[wr_ptr_q] <= (imem_inst == 32'h0);
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_inst  = fifo_inst_q[rd_ptr_q];
  assign out_fault = fifo_fault_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a registered ROM model of 59 words.
module tb_inst_fetch_unit;

  localparam int DEPTH    = 4;
  localparam int ROM_SIZE = 59;

  logic        clk_50;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [ROM_SIZE];

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_fault   (out_fault)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  function automatic logic [31:0] romRead(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx < 30'(ROM_SIZE)) return rom[int'(idx)];
    return 32'h0;
  endfunction

  // Synchronous ROM: data reflects the address of the previous cycle.
  initial imem_inst = 32'h0;
  always @(posedge clk_50) imem_inst <= romRead(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdir, input logic [31:0] rpc,
                               input logic rdy);
    redirect    = rdir;
    redirect_pc = rpc;
    out_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  // The FIFO must never be pushed beyond its capacity.
  always @(negedge clk_50) begin
    if (rst_n === 1'b1) checkOutput("fifo_count_bound", 32'(dut.count_q <= 3'd4), 32'd1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < ROM_SIZE; i++)
      rom[i] = (i < 17) ? 32'h0000_0013 : (32'h0000_0093 | (32'(i) << 20));
    rom[17] = 32'h0030_0693;
    rom[58] = 32'h00a5_4533;

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Reset values
    repeat (2) @(negedge clk_50);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_inst", out_inst, 32'h0);
    checkOutput("rst_out_fault", 32'(out_fault), 32'h0);

    // Streaming after reset release
    rst_n = 1'b1;
    checkOutput("t1_cycle0_addr", imem_addr, 32'h0);
    step();
    checkOutput("t1_cycle1_valid", 32'(out_valid), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t1_valid", 32'(out_valid), 32'h1);
      checkOutput("t1_pc", out_pc, 32'(4 * i));
      checkOutput("t1_inst", out_inst, 32'h0000_0013);
      step();
    end

    // Backpressure fills the FIFO and stalls fetch
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    checkOutput("t2_addr_stall", imem_addr, 32'd16);
    checkOutput("t2_count_full", 32'(dut.count_q), 32'd4);
    checkOutput("t2_head_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_drain_valid", 32'(out_valid), 32'h1);
      checkOutput("t2_drain_pc", out_pc, 32'(4 * i));
      step();
    end

    // Redirect while the FIFO is full
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (6) step();
    checkOutput("t3_full_count", 32'(dut.count_q), 32'd4);
    checkOutput("t3_full_head", out_pc, 32'd24);
    applyStimulus(1'b1, 32'd68, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_gap1_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("t3_gap2_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("t3_valid", 32'(out_valid), 32'h1);
    checkOutput("t3_pc", out_pc, 32'd68);
    checkOutput("t3_inst", out_inst, 32'h0030_0693);
    checkOutput("t3_fault", 32'(out_fault), 32'h0);

    // Redirect coinciding with a handshake
    applyStimulus(1'b1, 32'd164, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_gap1_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("t4_gap2_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("t4_valid", 32'(out_valid), 32'h1);
    checkOutput("t4_pc", out_pc, 32'd164);

    // Back-to-back redirects: the second target wins
    applyStimulus(1'b1, 32'd100, 1'b1);
    step();
    applyStimulus(1'b1, 32'd200, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("b2b_gap1_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("b2b_gap2_valid", 32'(out_valid), 32'h0);
    step();
    checkOutput("b2b_pc", out_pc, 32'd200);
    step();
    checkOutput("b2b_next_pc", out_pc, 32'd204);

    // Unaligned target is word aligned; fetch runs off the end of the ROM
    applyStimulus(1'b1, 32'd234, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    step();
    checkOutput("t5_last_pc", out_pc, 32'd232);
    checkOutput("t5_last_inst", out_inst, 32'h00a5_4533);
    checkOutput("t5_last_fault", 32'(out_fault), 32'h0);
    step();
    checkOutput("t5_past_valid", 32'(out_valid), 32'h1);
    checkOutput("t5_past_pc", out_pc, 32'd236);
    checkOutput("t5_past_inst", out_inst, 32'h0);
    checkOutput("t5_past_fault", 32'(out_fault), 32'h1);

    // Asynchronous reset with three words buffered
    applyStimulus(1'b1, 32'd64, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (4) step();
    checkOutput("t6_pre_count", 32'(dut.count_q), 32'd3);
    checkOutput("t6_pre_head", out_pc, 32'd64);
    checkOutput("t6_pre_addr", imem_addr, 32'd80);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'h0);
    checkOutput("t6_async_addr", imem_addr, 32'h0);
    checkOutput("t6_async_pc", out_pc, 32'h0);
    checkOutput("t6_async_inst", out_inst, 32'h0);
    @(negedge clk_50);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_restart_addr", imem_addr, 32'h0);
    step();
    checkOutput("t6_restart_gap", 32'(out_valid), 32'h0);
    step();
    checkOutput("t6_restart_valid", 32'(out_valid), 32'h1);
    checkOutput("t6_restart_pc0", out_pc, 32'h0);
    step();
    checkOutput("t6_restart_pc4", out_pc, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
